// File: rtl/fixed_point_argmax.sv
// fixed_point_argmax: streaming argmax over NUM_INPUTS signed fixed-point samples.
// Define FIXED_POINT_ARGMAX_TIES_LAST_EN to make ties report the latest index instead of the earliest.
module fixed_point_argmax #(
   parameter int WIDTH      = 8,
   parameter int FRAC_BITS  = 3,
   parameter int NUM_INPUTS = 10,
   parameter int IDX_WIDTH  = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
   input  logic                        CLK,
   input  logic                        RSTN,
   input  logic                        START,
   input  logic signed [WIDTH-1:0]     VALUE_IN,
   input  logic                        VALUE_VALID_IN,
   output logic                        VALUE_READY_OUT,
   output logic signed [WIDTH-1:0]     MAX_VALUE_OUT,
   output logic        [IDX_WIDTH-1:0] MAX_INDEX_OUT,
   output logic                        RESULT_VALID_OUT,
   input  logic                        RESULT_READY_IN,
   output logic                        BUSY_OUT
);
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] SCAN = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   if (NUM_INPUTS < 1 || NUM_INPUTS > 256 || FRAC_BITS < 0 || FRAC_BITS >= WIDTH) begin : g_bad_param
      $error("fixed_point_argmax: illegal parameter combination");
   end

   logic [1:0]           state;
   logic [IDX_WIDTH-1:0] cnt;
   logic                 better;
   logic                 last;

`ifdef FIXED_POINT_ARGMAX_TIES_LAST_EN
   assign better = VALUE_IN >= MAX_VALUE_OUT;
`else
   assign better = VALUE_IN > MAX_VALUE_OUT;
`endif
   assign last             = cnt == IDX_WIDTH'(NUM_INPUTS - 1);
   assign VALUE_READY_OUT  = state == SCAN;
   assign RESULT_VALID_OUT = state == DONE;
   assign BUSY_OUT         = state != IDLE;

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         state         <= IDLE;
         cnt           <= '0;
         MAX_VALUE_OUT <= '0;
         MAX_INDEX_OUT <= '0;
      end else begin
         case (state)
            IDLE: if (START) begin
               state <= SCAN;
               cnt   <= '0;
            end
            SCAN: if (VALUE_VALID_IN) begin
               // sample 0 loads unconditionally so the most negative value is still captured
               if (cnt == '0 || better) begin
                  MAX_VALUE_OUT <= VALUE_IN;
                  MAX_INDEX_OUT <= cnt;
               end
               if (last) state <= DONE;
               else cnt <= cnt + 1'b1;
            end
            DONE: if (RESULT_READY_IN) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_fixed_point_argmax.sv
// tb_fixed_point_argmax: directed checks of the argmax scanner (NUM_INPUTS=10 and NUM_INPUTS=1 instances).
module tb_fixed_point_argmax;
`ifdef FIXED_POINT_ARGMAX_TIES_LAST_EN
   localparam int TIE_BASIC = 7;
   localparam int TIE_EQ    = 9;
`else
   localparam int TIE_BASIC = 2;
   localparam int TIE_EQ    = 0;
`endif
   logic       clk = 0, rstn, start, valid, ready_in;
   logic [7:0] value;
   logic       ready_out, result_valid, busy;
   logic [7:0] max_value;
   logic [3:0] max_index;
   logic       start1, valid1, ready_in1;
   logic [7:0] value1;
   logic       ready_out1, result_valid1, busy1;
   logic [7:0] max_value1;
   logic [0:0] max_index1;
   logic [7:0] vec [10];
   int         total = 0, passed = 0;

   always #5 clk = ~clk;

   fixed_point_argmax dut (
      .CLK(clk), .RSTN(rstn), .START(start), .VALUE_IN(value), .VALUE_VALID_IN(valid),
      .VALUE_READY_OUT(ready_out), .MAX_VALUE_OUT(max_value), .MAX_INDEX_OUT(max_index),
      .RESULT_VALID_OUT(result_valid), .RESULT_READY_IN(ready_in), .BUSY_OUT(busy)
   );

   fixed_point_argmax #(.NUM_INPUTS(1)) dut1 (
      .CLK(clk), .RSTN(rstn), .START(start1), .VALUE_IN(value1), .VALUE_VALID_IN(valid1),
      .VALUE_READY_OUT(ready_out1), .MAX_VALUE_OUT(max_value1), .MAX_INDEX_OUT(max_index1),
      .RESULT_VALID_OUT(result_valid1), .RESULT_READY_IN(ready_in1), .BUSY_OUT(busy1)
   );

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // Launch a scan of vec; optional random stalls and a START pulse alongside sample 4.
   task automatic feed(input bit gaps, input bit start_mid);
      start = 1;
      step;
      start = 0;
      chk("scan_ready", ready_out, 1);
      chk("scan_busy", busy, 1);
      for (int i = 0; i < 10; i++) begin
         if (gaps) begin
            valid = 0;
            value = 8'h7f;
            repeat ($urandom_range(0, 3)) step;
         end
         value = vec[i];
         valid = 1;
         start = start_mid && i == 4;
         step;
         start = 0;
         if (i == 8) chk("no_early_result", result_valid, 0);
      end
      valid = 0;
      chk("result_valid_rise", result_valid, 1);
   endtask

   initial begin
      rstn = 0; start = 0; valid = 0; value = 0; ready_in = 0;
      start1 = 0; valid1 = 0; value1 = 0; ready_in1 = 0;
      step;
      chk("rst_max_value", max_value, 0);
      chk("rst_max_index", max_index, 0);
      chk("rst_result_valid", result_valid, 0);
      chk("rst_ready", ready_out, 0);
      chk("rst_busy", busy, 0);
      rstn = 1;
      step;
      chk("idle_ready", ready_out, 0);

      vec = '{8'h08, 8'hF0, 8'h1C, 8'h04, 8'h1B, 8'h80, 8'h00, 8'h1C, 8'h10, 8'hFF};
      feed(0, 1);
      chk("basic_max_value", max_value, 8'h1C);
      chk("basic_max_index", max_index, TIE_BASIC);
      chk("done_ready", ready_out, 0);
      chk("done_busy", busy, 1);
      for (int c = 0; c < 5; c++) begin
         start = c[0];
         step;
         chk("bp_valid", result_valid, 1);
         chk("bp_max_value", max_value, 8'h1C);
         chk("bp_max_index", max_index, TIE_BASIC);
         chk("bp_ready", ready_out, 0);
      end
      ready_in = 1;
      start = 1;
      step;
      ready_in = 0;
      start = 0;
      chk("handshake_drop", result_valid, 0);
      chk("handshake_idle", busy, 0);
      step;
      chk("start_on_hs_ignored", busy, 0);
      chk("idle_retain_value", max_value, 8'h1C);
      chk("idle_retain_index", max_index, TIE_BASIC);

      feed(1, 0);
      chk("stall_max_value", max_value, 8'h1C);
      chk("stall_max_index", max_index, TIE_BASIC);
      ready_in = 1;
      step;
      ready_in = 0;

      vec = '{8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'hF8};
      feed(0, 0);
      chk("neg_max_value", max_value, 8'hF8);
      chk("neg_max_index", max_index, 9);
      ready_in = 1;
      step;
      ready_in = 0;

      vec = '{8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80};
      feed(1, 0);
      chk("eq_max_value", max_value, 8'h80);
      chk("eq_max_index", max_index, TIE_EQ);
      ready_in = 1;
      step;
      ready_in = 0;

      start1 = 1;
      step;
      start1 = 0;
      chk("n1_ready", ready_out1, 1);
      value1 = 8'h7F;
      valid1 = 1;
      step;
      valid1 = 0;
      chk("n1_result_valid", result_valid1, 1);
      chk("n1_max_value", max_value1, 8'h7F);
      chk("n1_max_index", max_index1, 0);

      start = 1;
      step;
      start = 0;
      valid = 1;
      for (int i = 0; i < 4; i++) begin
         value = 8'h10 + 8'(i);
         step;
      end
      valid = 0;
      #2 rstn = 0;
      #1;
      chk("midscan_rst_value", max_value, 0);
      chk("midscan_rst_index", max_index, 0);
      chk("midscan_rst_busy", busy, 0);
      chk("midscan_rst_ready", ready_out, 0);
      chk("midscan_rst_n1_valid", result_valid1, 0);
      step;
      rstn = 1;
      step;
      chk("post_rst_ready", ready_out, 0);
      chk("post_rst_valid", result_valid, 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
